// File: rtl/ula_wb_stage.sv
// ula_wb_stage -- result/flag capture stage behind the 32-bit ALU.
//
// Registers the ALU bundle {s, fov, fz, fn} in a 2-entry FIFO behind a
// valid/ready handshake. The branch condition and the unsupported-select
// error bit are resolved at push time and stored with each entry. A counter
// tracks retired (popped) entries.
//
// Optional feature: define ULA_WB_STICKY_OV_EN to build the sticky overflow
// status bit. When it is undefined, ov_sticky_o is tied to 0 and ov_clr_i is
// ignored.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   in_valid_i/in_ready_o input handshake for the ALU bundle
//   alu_s_i, alu_f*_i     ALU result and overflow/zero/negative flags
//   alu_sel_i, cond_i     ALU select and branch condition for this bundle
//   out_valid_o/ready_i   output handshake for the head entry
//   out_data_o            head result
//   out_flags_o           head {fov,fz,fn}
//   out_take_o            head branch condition true
//   out_err_o             head was produced with alu_sel 3'b011
//   ov_clr_i, ov_sticky_o sticky overflow clear / status
//   op_cnt_o              popped-entry counter, wraps
module ula_wb_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      alu_s_i,
   input  logic             alu_fov_i,
   input  logic             alu_fz_i,
   input  logic             alu_fn_i,
   input  logic [2:0]       alu_sel_i,
   input  logic [2:0]       cond_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_data_o,
   output logic [2:0]       out_flags_o,
   output logic             out_take_o,
   output logic             out_err_o,
   input  logic             ov_clr_i,
   output logic             ov_sticky_o,
   output logic [CNT_W-1:0] op_cnt_o
);

   typedef struct packed {
      logic [31:0] s;
      logic        fov;
      logic        fz;
      logic        fn;
      logic        take;
      logic        err;
   } ent_t;

   ent_t             mem_q [2];
   ent_t             in_ent, head;
   logic [1:0]       count_q, count_d;
   logic             rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
   logic             init_q;
   logic             push, pop, cond_ok;

   // init_q holds in_ready low until the first edge with reset released.
   assign in_ready_o  = rst_n_i & init_q & (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      cond_ok = 1'b0;
      unique case (cond_i)
         3'b000: cond_ok = 1'b0;
         3'b001: cond_ok = 1'b1;
         3'b010: cond_ok = alu_fz_i;
         3'b011: cond_ok = ~alu_fz_i;
         3'b100: cond_ok = alu_fn_i ^ alu_fov_i;
         3'b101: cond_ok = ~(alu_fn_i ^ alu_fov_i);
         3'b110: cond_ok = alu_fov_i;
         3'b111: cond_ok = ~alu_fov_i;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      in_ent.s    = alu_s_i;
      in_ent.fov  = alu_fov_i;
      in_ent.fz   = alu_fz_i;
      in_ent.fn   = alu_fn_i;
      in_ent.err  = (alu_sel_i == 3'b011);
      // Unsupported select still delivers its entry, but never branches.
      in_ent.take = cond_ok & ~in_ent.err;
   end

   always_comb begin
      count_d  = count_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      op_cnt_d = op_cnt_q;
      if (push) wr_d = ~wr_q;
      if (pop) begin
         rd_d     = ~rd_q;
         op_cnt_d = op_cnt_q + CNT_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count_q  <= 2'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         op_cnt_q <= '0;
         init_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         op_cnt_q <= op_cnt_d;
         init_q   <= 1'b1;
      end
   end

   // Entry storage needs no reset: reads are masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= in_ent;
   end

   assign head        = out_valid_o ? mem_q[rd_q] : '0;
   assign out_data_o  = head.s;
   assign out_flags_o = {head.fov, head.fz, head.fn};
   assign out_take_o  = head.take;
   assign out_err_o   = head.err;
   assign op_cnt_o    = op_cnt_q;

`ifdef ULA_WB_STICKY_OV_EN
   logic ov_q, ov_d, ov_set;

   // Only selects 010 and 110 can produce a meaningful overflow.
   assign ov_set = push & alu_fov_i & ((alu_sel_i == 3'b010) | (alu_sel_i == 3'b110));

   always_comb begin
      ov_d = ov_q;
      if (ov_clr_i) ov_d = 1'b0;
      if (ov_set)   ov_d = 1'b1;   // set wins over a same-cycle clear
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) ov_q <= 1'b0;
      else          ov_q <= ov_d;
   end

   assign ov_sticky_o = ov_q;
`else
   logic unused_ov_clr;
   assign unused_ov_clr = ov_clr_i;
   assign ov_sticky_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ula_wb_stage.sv
module tb_ula_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] alu_s, out_data;
   logic        alu_fov, alu_fz, alu_fn, out_take, out_err, ov_clr, ov_sticky;
   logic [2:0]  alu_sel, cond, out_flags;
   logic [15:0] op_cnt;

   ula_wb_stage #(.CNT_W(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .alu_s_i(alu_s), .alu_fov_i(alu_fov), .alu_fz_i(alu_fz), .alu_fn_i(alu_fn),
      .alu_sel_i(alu_sel), .cond_i(cond), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_data_o(out_data), .out_flags_o(out_flags),
      .out_take_o(out_take), .out_err_o(out_err), .ov_clr_i(ov_clr),
      .ov_sticky_o(ov_sticky), .op_cnt_o(op_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] s;
      logic [2:0]  f;
      logic        take;
      logic        err;
   } ent_t;

   ent_t        q[$];
   logic [15:0] m_cnt;
   logic        m_sticky, m_init;
   int          n_cmp = 0, n_err = 0;

`ifdef ULA_WB_STICKY_OV_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Branch truth derived from the condition name: signed "less than" after
   // a subtract is N != V.
   function automatic logic branch(input logic [2:0] c, input logic v, input logic z, input logic n);
      logic lt;
      lt = (n != v);
      case (c)
         3'd0: return 1'b0;
         3'd1: return 1'b1;
         3'd2: return z;
         3'd3: return !z;
         3'd4: return lt;
         3'd5: return !lt;
         3'd6: return v;
         default: return !v;
      endcase
   endfunction

   function automatic logic m_rdy();
      return rst_n && m_init && (q.size() < 2);
   endfunction

   task automatic check_all();
      chk("in_ready", in_ready, m_rdy());
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0].s);
         chk("out_flags", out_flags, q[0].f);
         chk("out_take", out_take, q[0].take);
         chk("out_err", out_err, q[0].err);
      end else begin
         chk("out_data_z", out_data, 0);
         chk("out_misc_z", {out_flags, out_take, out_err}, 0);
      end
      chk("ov_sticky", ov_sticky, m_sticky);
      chk("op_cnt", op_cnt, m_cnt);
   endtask

   // One clock: check outputs at negedge, update model at posedge, return #1 later.
   task automatic cycle();
      logic push, pop;
      ent_t e;
      @(negedge clk);
      check_all();
      push = in_valid && m_rdy();
      pop  = (q.size() != 0) && out_ready;
      e.s    = alu_s;
      e.f    = {alu_fov, alu_fz, alu_fn};
      e.err  = (alu_sel == 3'b011);
      e.take = e.err ? 1'b0 : branch(cond, alu_fov, alu_fz, alu_fn);
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_cnt = 0; m_sticky = 0; m_init = 0;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (push) q.push_back(e);
         if (STICKY) begin
            if (push && alu_fov && (alu_sel == 3'd2 || alu_sel == 3'd6)) m_sticky = 1'b1;
            else if (ov_clr) m_sticky = 1'b0;
         end
         m_init = 1'b1;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] s, input logic [2:0] f,
                        input logic [2:0] sel, input logic [2:0] c,
                        input logic ordy, input logic clr);
      in_valid = v; alu_s = s; {alu_fov, alu_fz, alu_fn} = f;
      alu_sel = sel; cond = c; out_ready = ordy; ov_clr = clr;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 32'h0, 3'b000, 3'b000, 3'b000, ordy, 1'b0);
   endtask

   initial begin
      m_cnt = 0; m_sticky = 0; m_init = 0;
      rst_n = 1'b0;
      idle(1'b0);
      cycle(); cycle();
      chk("rst_valid", out_valid, 0);
      rst_n = 1'b1;
      chk("rst_ready_low", in_ready, 0);   // no edge with reset high yet
      cycle();
      chk("rst_ready_up", in_ready, 1);

      // single push
      drive(1'b1, 32'h5, 3'b000, 3'b010, 3'b011, 1'b0, 1'b0);
      cycle();
      idle(1'b0);
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 32'h5);
      chk("single_take", out_take, 1);
      idle(1'b1);
      cycle();
      chk("single_opcnt", op_cnt, 1);
      chk("single_empty", out_valid, 0);

      // backpressure
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 32'(i), 3'b000, 3'b000, 3'b001, 1'b0, 1'b0);
         cycle();
         if (i == 2) chk("bp_ready_low", in_ready, 0);
      end
      chk("bp_head", out_data, 32'd1);
      idle(1'b1);
      cycle();
      chk("bp_second", out_data, 32'd2);
      cycle();
      chk("bp_drained", out_valid, 0);
      chk("bp_opcnt", op_cnt, 3);

      // condition codes
      drive(1'b1, 32'hA, 3'b001, 3'b000, 3'b100, 1'b1, 1'b0); cycle();
      chk("cc_lt_take", out_take, 1);
      drive(1'b1, 32'hB, 3'b101, 3'b000, 3'b100, 1'b1, 1'b0); cycle();
      chk("cc_lt_ovf", out_take, 0);
      drive(1'b1, 32'hC, 3'b000, 3'b011, 3'b001, 1'b1, 1'b0); cycle();
      chk("cc_err", {out_err, out_take}, 2'b10);
      idle(1'b1); cycle();

      // sticky overflow
      drive(1'b1, 32'h1, 3'b100, 3'b010, 3'b000, 1'b1, 1'b0); cycle();
      chk("ov_set", ov_sticky, STICKY);
      drive(1'b1, 32'h2, 3'b100, 3'b110, 3'b000, 1'b1, 1'b1); cycle();
      chk("ov_set_wins", ov_sticky, STICKY);
      drive(1'b0, 32'h0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1); cycle();
      chk("ov_clr", ov_sticky, 0);
      drive(1'b1, 32'h3, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0); cycle();
      chk("ov_and_noset", ov_sticky, 0);
      idle(1'b1); cycle();

      // reset with two entries buffered
      drive(1'b1, 32'h11, 3'b100, 3'b010, 3'b000, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h22, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0); cycle();
      chk("mid_full", in_ready, 0);
      idle(1'b0);
      rst_n = 1'b0; cycle();
      rst_n = 1'b1;
      chk("mid_valid", out_valid, 0);
      chk("mid_opcnt", op_cnt, 0);
      chk("mid_sticky", ov_sticky, 0);
      cycle();
      chk("mid_ready", in_ready, 1);

      // stream 100 bundles with out_ready high
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 32'h1000 + 32'(i), 3'($urandom_range(0, 7)), 3'd0, 3'd1, 1'b1, 1'b0);
         cycle();
      end
      idle(1'b1); cycle(); cycle();
      chk("stream_opcnt", op_cnt, 100);

      // randomized traffic, occasional reset
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         drive(1'($urandom), $urandom, 3'($urandom), 3'($urandom), 3'($urandom),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
         cycle();
      end
      rst_n = 1'b1;
      idle(1'b1); cycle(); cycle(); cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
